// File: rtl/util_axis_sfifo.sv
// util_axis_sfifo
// Single-clock AXI-Stream FIFO with a registered output stage. Beats carry
// tdata/tkeep/tlast/tuser/tdest together. In packet mode the read side only
// presents beats once a complete packet (tlast) has been stored. The one
// exception is a packet larger than the FIFO: it is released so it cannot
// deadlock.
//
// Ports
//   aclk, arstn            clock (rising edge), asynchronous active-low reset
//   s_axis_*               write stream (tready is registered)
//   m_axis_*               read stream (fields come from the output register)
//   data_count             beats accepted but not yet delivered
//   pkt_count              tlast beats accepted but not yet delivered
//   full, empty            count == FIFO_DEPTH / count == 0
//   almost_full            count >= ALMOST_FULL
//   almost_empty           count <= ALMOST_EMPTY
module util_axis_sfifo #(
   parameter int FIFO_DEPTH   = 256,
   parameter int COUNT_WIDTH  = 9,
   parameter int BUS_WIDTH    = 1,
   parameter int USER_WIDTH   = 1,
   parameter int DEST_WIDTH   = 1,
   parameter int PACKET_MODE  = 0,
   parameter int ALMOST_FULL  = FIFO_DEPTH - 4,
   parameter int ALMOST_EMPTY = 4
) (
   input  logic                     aclk,
   input  logic                     arstn,
   input  logic                     s_axis_tvalid,
   output logic                     s_axis_tready,
   input  logic [8*BUS_WIDTH-1:0]   s_axis_tdata,
   input  logic [BUS_WIDTH-1:0]     s_axis_tkeep,
   input  logic                     s_axis_tlast,
   input  logic [USER_WIDTH-1:0]    s_axis_tuser,
   input  logic [DEST_WIDTH-1:0]    s_axis_tdest,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic [8*BUS_WIDTH-1:0]   m_axis_tdata,
   output logic [BUS_WIDTH-1:0]     m_axis_tkeep,
   output logic                     m_axis_tlast,
   output logic [USER_WIDTH-1:0]    m_axis_tuser,
   output logic [DEST_WIDTH-1:0]    m_axis_tdest,
   output logic [COUNT_WIDTH-1:0]   data_count,
   output logic [COUNT_WIDTH-1:0]   pkt_count,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty
);

   localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH);
   localparam int BEAT_WIDTH = 8*BUS_WIDTH + BUS_WIDTH + 1 + USER_WIDTH + DEST_WIDTH;
   localparam logic [COUNT_WIDTH-1:0] DEPTH_C = COUNT_WIDTH'(FIFO_DEPTH);
   localparam logic [COUNT_WIDTH-1:0] AF_C    = COUNT_WIDTH'(ALMOST_FULL);
   localparam logic [COUNT_WIDTH-1:0] AE_C    = COUNT_WIDTH'(ALMOST_EMPTY);
   localparam logic [COUNT_WIDTH-1:0] ONE_C   = COUNT_WIDTH'(1);

   logic [BEAT_WIDTH-1:0]  mem [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0]  wr_ptr;
   logic [ADDR_WIDTH-1:0]  rd_ptr;
   logic [BEAT_WIDTH-1:0]  s_beat;
   logic [BEAT_WIDTH-1:0]  out_beat;
   logic                   out_valid;
   logic                   release_q;
   logic                   accept;
   logic                   deliver;
   logic                   mem_avail;
   logic                   load_out;
   logic                   accept_last;
   logic                   deliver_last;
   logic [COUNT_WIDTH-1:0] count_next;
   logic [COUNT_WIDTH-1:0] pkt_next;

   assign s_beat = {s_axis_tlast, s_axis_tdest, s_axis_tuser, s_axis_tkeep, s_axis_tdata};
   assign {m_axis_tlast, m_axis_tdest, m_axis_tuser, m_axis_tkeep, m_axis_tdata} = out_beat;

   // In packet mode the output register is hidden until its packet is complete
   // (any stored tlast means the head packet is complete, since order is kept)
   // or the oversize-packet release is active.
   assign m_axis_tvalid = (PACKET_MODE != 0) ? (out_valid & ((pkt_count != '0) | release_q))
                                             : out_valid;

   assign accept       = s_axis_tvalid & s_axis_tready;
   assign deliver      = m_axis_tvalid & m_axis_tready;
   assign accept_last  = accept & s_axis_tlast;
   assign deliver_last = deliver & m_axis_tlast;

   // data_count includes the output register, so the memory holds something
   // exactly when the count exceeds the output register's own contribution.
   // Beats written this edge are not visible yet, which gives the one-cycle
   // latency and rules out fall-through.
   assign mem_avail = (data_count != {{(COUNT_WIDTH-1){1'b0}}, out_valid});
   assign load_out  = mem_avail & (~out_valid | deliver);

   // Next-state beat and packet counts.
   always_comb begin
      count_next = data_count;
      pkt_next   = pkt_count;
      case ({accept, deliver})
         2'b10:   count_next = data_count + ONE_C;
         2'b01:   count_next = data_count - ONE_C;
         default: count_next = data_count;
      endcase
      case ({accept_last, deliver_last})
         2'b10:   pkt_next = pkt_count + ONE_C;
         2'b01:   pkt_next = pkt_count - ONE_C;
         default: pkt_next = pkt_count;
      endcase
   end

   // Storage array; no reset, since the pointers define what is valid.
   always_ff @(posedge aclk) begin
      if (accept) begin
         mem[wr_ptr] <= s_beat;
      end
   end

   // Pointers and output register.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         out_valid <= 1'b0;
         out_beat  <= '0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (load_out) begin
            rd_ptr    <= rd_ptr + 1'b1;
            out_valid <= 1'b1;
            out_beat  <= mem[rd_ptr];
         end else if (deliver) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Counts, flags and tready, all registered from next-state counts.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         data_count    <= '0;
         pkt_count     <= '0;
         s_axis_tready <= 1'b0;
         full          <= 1'b0;
         empty         <= 1'b1;
         almost_full   <= 1'b0;
         almost_empty  <= 1'b1;
      end else begin
         data_count    <= count_next;
         pkt_count     <= pkt_next;
         s_axis_tready <= (count_next < DEPTH_C);
         full          <= (count_next == DEPTH_C);
         empty         <= (count_next == '0);
         almost_full   <= (count_next >= AF_C);
         almost_empty  <= (count_next <= AE_C);
      end
   end

   // Oversize-packet escape. A full FIFO with no complete packet would never
   // drain, so it streams until the packet's tlast leaves.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         release_q <= 1'b0;
      end else if (PACKET_MODE != 0) begin
         if (deliver_last) begin
            release_q <= 1'b0;
         end else if ((count_next == DEPTH_C) && (pkt_next == '0)) begin
            release_q <= 1'b1;
         end
      end
   end

endmodule
